// File: rtl/quad_esc_pwm.sv
// quad_esc_pwm: four-channel servo-style ESC pulse generator with an arming sequencer.
// Pulse widths reload only at frame end, so disarm is the only thing that can cut a pulse short.
module quad_esc_pwm #(
    parameter int unsigned FRAME_CYCLES = 1_000_000,
    parameter int unsigned BASE_CYCLES  = 50_000,
    parameter int unsigned SHIFT        = 4,
    parameter int unsigned ARM_FRAMES   = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arm,
    input  logic        upd,
    input  logic [10:0] frnt_spd,
    input  logic [10:0] bck_spd,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
    output logic        frnt,
    output logic        bck,
    output logic        lft,
    output logic        rght,
    output logic        frm_strt,
    output logic        armed
);
    localparam int unsigned ACW = (ARM_FRAMES > 1) ? $clog2(ARM_FRAMES) : 1;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMING   = 2'd1,
        ARMED    = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [ACW-1:0]  arm_cnt_q, arm_cnt_d;
    logic [19:0]     frm_cnt_q, frm_cnt_d;
    logic [10:0]     spd_in [4];
    logic [10:0]     shd_q  [4];
    logic [10:0]     shd_d  [4];
    logic [19:0]     wid_q  [4];
    logic [19:0]     wid_d  [4];
    logic [3:0]      pwm_q, pwm_d;
    logic            frm_strt_q, frm_strt_d;
    logic            armed_q, armed_d;
    logic            frame_end;

    assign spd_in[0] = frnt_spd;
    assign spd_in[1] = bck_spd;
    assign spd_in[2] = lft_spd;
    assign spd_in[3] = rght_spd;

    assign frame_end = (frm_cnt_q == 20'(FRAME_CYCLES - 1));
    assign frm_cnt_d = frame_end ? '0 : frm_cnt_q + 20'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DISARMED;
            arm_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            arm_cnt_q <= arm_cnt_d;
        end
    end

    // Dropping arm wins over everything, on any edge.
    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        if (!arm) begin
            state_d = DISARMED;
        end else if (frame_end) begin
            unique case (state_q)
                DISARMED: begin
                    state_d   = ARMING;
                    arm_cnt_d = '0;
                end
                ARMING: begin
                    if (arm_cnt_q == ACW'(ARM_FRAMES - 1)) state_d = ARMED;
                    else arm_cnt_d = arm_cnt_q + ACW'(1);
                end
                default: ;
            endcase
        end
    end

    // shd_d already carries the bypass: with upd on the frame-end edge the fresh speed is used.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            shd_d[i] = upd ? spd_in[i] : shd_q[i];
            wid_d[i] = wid_q[i];
            if (!arm || frame_end) begin
                unique case (state_d)
                    ARMED:   wid_d[i] = 20'(BASE_CYCLES) + (20'(shd_d[i]) << SHIFT);
                    ARMING:  wid_d[i] = 20'(BASE_CYCLES);
                    default: wid_d[i] = '0;
                endcase
            end
        end
    end

    always_comb begin
        armed_d    = (state_d == ARMED);
        frm_strt_d = (frm_cnt_q == '0);
        for (int i = 0; i < 4; i++) begin
            pwm_d[i] = (frm_cnt_q < wid_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frm_cnt_q  <= '0;
            pwm_q      <= '0;
            frm_strt_q <= 1'b0;
            armed_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shd_q[i] <= '0;
                wid_q[i] <= '0;
            end
        end else begin
            frm_cnt_q  <= frm_cnt_d;
            pwm_q      <= pwm_d;
            frm_strt_q <= frm_strt_d;
            armed_q    <= armed_d;
            for (int i = 0; i < 4; i++) begin
                shd_q[i] <= shd_d[i];
                wid_q[i] <= wid_d[i];
            end
        end
    end

    assign frnt     = pwm_q[0];
    assign bck      = pwm_q[1];
    assign lft      = pwm_q[2];
    assign rght     = pwm_q[3];
    assign frm_strt = frm_strt_q;
    assign armed    = armed_q;
endmodule

// File: tb/tb_quad_esc_pwm.sv
// tb_quad_esc_pwm: frame-level reference model feeds a scoreboard; a monitor measures each
// frame's pulse widths, frm_strt placement and armed level and compares against it.
module tb_quad_esc_pwm;
    localparam int FC   = 4000;
    localparam int BASE = 100;
    localparam int SH   = 0;
    localparam int AF   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm = 1'b0;
    logic        upd = 1'b0;
    logic [10:0] frnt_spd = '0;
    logic [10:0] bck_spd  = '0;
    logic [10:0] lft_spd  = '0;
    logic [10:0] rght_spd = '0;
    logic        frnt, bck, lft, rght, frm_strt, armed;

    always #5 clk = ~clk;

    quad_esc_pwm #(
        .FRAME_CYCLES(FC),
        .BASE_CYCLES (BASE),
        .SHIFT       (SH),
        .ARM_FRAMES  (AF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .arm     (arm),
        .upd     (upd),
        .frnt_spd(frnt_spd),
        .bck_spd (bck_spd),
        .lft_spd (lft_spd),
        .rght_spd(rght_spd),
        .frnt    (frnt),
        .bck     (bck),
        .lft     (lft),
        .rght    (rght),
        .frm_strt(frm_strt),
        .armed   (armed)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic             armed;
        logic [3:0][19:0] w;
    } exp_t;
    exp_t sbq[$];

    // Reference model state: 0 = off, 1 = arming, 2 = armed.
    int m_state  = 0;
    int m_frames = 0;
    int m_w[4]   = '{0, 0, 0, 0};
    int m_shd[4] = '{0, 0, 0, 0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic drive_spd(input logic [3:0][10:0] s);
        frnt_spd = s[0];
        bck_spd  = s[1];
        lft_spd  = s[2];
        rght_spd = s[3];
    endtask

    // Runs one frame, starting just before the edge where the DUT counter reads 0.
    task automatic run_frame(input logic a, input int ka, input logic u, input int ku,
                             input logic [3:0][10:0] su, input logic bp,
                             input logic [3:0][10:0] sb);
        int   e = 0;
        exp_t ex;
        while (e < ka) begin
            @(posedge clk); #1; e++;
        end
        arm = a;
        if (!a) begin
            @(posedge clk); e++;
            @(negedge clk);
            chk("disarm_armed_low", 32'(armed), 32'd0);
            @(posedge clk); e++;
            @(negedge clk);
            chk("disarm_pwm_low", 32'({frnt, bck, lft, rght}), 32'd0);
        end
        if (u) begin
            while (e < ku) begin
                @(posedge clk); #1; e++;
            end
            drive_spd(su);
            upd = 1'b1;
            @(posedge clk); #1; e++;
            upd = 1'b0;
        end
        while (e < FC - 1) begin
            @(posedge clk); #1; e++;
        end
        if (bp) begin
            drive_spd(sb);
            upd = 1'b1;
        end
        @(posedge clk); #1;
        upd = 1'b0;

        ex.armed = (m_state == 2);
        for (int i = 0; i < 4; i++)
            ex.w[i] = 20'((!a && (ka + 1 < m_w[i])) ? ka + 1 : m_w[i]);
        sbq.push_back(ex);

        if (u)  for (int i = 0; i < 4; i++) m_shd[i] = int'(su[i]);
        if (bp) for (int i = 0; i < 4; i++) m_shd[i] = int'(sb[i]);
        if (!a) begin
            m_state = 0;
            for (int i = 0; i < 4; i++) m_w[i] = 0;
        end else if (m_state == 0) begin
            m_state  = 1;
            m_frames = 0;
            for (int i = 0; i < 4; i++) m_w[i] = BASE;
        end else begin
            if (m_state == 1) begin
                m_frames++;
                if (m_frames == AF) m_state = 2;
            end
            for (int i = 0; i < 4; i++)
                m_w[i] = (m_state == 2) ? BASE + (m_shd[i] << SH) : BASE;
        end
    endtask

    // Monitor: one frame record per FC cycles after reset release.
    initial begin
        int         off   = 0;
        int         nstrt = 0;
        int         pc[4];
        int         fst[4];
        int         lst[4];
        logic       arm_s = 1'b0;
        logic [3:0] pw;
        exp_t       ex;
        for (int i = 0; i < 4; i++) begin
            pc[i] = 0; fst[i] = 0; lst[i] = 0;
        end
        wait (rst === 1'b1);
        wait (rst === 1'b0);
        @(posedge clk);
        forever begin
            @(negedge clk);
            pw = {rght, lft, bck, frnt};
            for (int i = 0; i < 4; i++) begin
                if (pw[i] === 1'b1) begin
                    if (pc[i] == 0) fst[i] = off;
                    pc[i]++;
                    lst[i] = off;
                end
            end
            if (frm_strt === 1'b1) nstrt++;
            if (off == 0) begin
                chk("frm_strt_at_frame_start", 32'(frm_strt), 32'd1);
                arm_s = armed;
            end
            if (off == FC - 1) begin
                chk("frm_strt_pulses_per_frame", 32'(nstrt), 32'd1);
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_underflow actual=empty required=record");
                end else begin
                    ex = sbq.pop_front();
                    for (int i = 0; i < 4; i++) begin
                        chk($sformatf("width_ch%0d", i), 32'(pc[i]), 32'(ex.w[i]));
                        chk($sformatf("pulse_at_start_ch%0d", i),
                            32'((pc[i] == 0) || (fst[i] == 0 && lst[i] == pc[i] - 1)), 32'd1);
                    end
                    chk("armed_level", 32'(arm_s), 32'(ex.armed));
                end
                for (int i = 0; i < 4; i++) pc[i] = 0;
                nstrt = 0;
                off   = 0;
            end else begin
                off++;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0][10:0] z, s1000, smap, s500, s1k, sbp, r1, r2;
        logic ra, ru, rb;
        int   rka, rku;
        z     = '0;
        s1000 = {11'd1000, 11'd1000, 11'd1000, 11'd1000};
        smap  = {11'd1, 11'd2047, 11'd500, 11'd0};
        s500  = {11'd1, 11'd2047, 11'd500, 11'd500};
        s1k   = {11'd1, 11'd2047, 11'd500, 11'd1000};
        sbp   = {11'd1, 11'd2047, 11'd500, 11'd300};

        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("reset_outputs", 32'({frnt, bck, lft, rght, frm_strt, armed}), 32'd0);
        end
        rst = 1'b0;

        run_frame(1'b0, 100,  1'b0, 0,    z,     1'b0, z);
        run_frame(1'b1, 1000, 1'b1, 1500, s1000, 1'b0, z);
        repeat (3) run_frame(1'b1, 1000, 1'b0, 0, z, 1'b0, z);
        run_frame(1'b1, 1000, 1'b1, 3000, smap,  1'b0, z);
        run_frame(1'b1, 1000, 1'b1, 3000, s500,  1'b0, z);
        run_frame(1'b1, 1000, 1'b1, 3000, s1k,   1'b0, z);
        run_frame(1'b1, 1000, 1'b0, 0,    z,     1'b0, z);
        run_frame(1'b1, 1000, 1'b0, 0,    z,     1'b1, sbp);
        run_frame(1'b0, 50,   1'b0, 0,    z,     1'b0, z);
        run_frame(1'b1, 1000, 1'b0, 0,    z,     1'b0, z);
        repeat (4) run_frame(1'b1, 1000, 1'b0, 0, z, 1'b0, z);

        for (int r = 0; r < 3; r++) begin
            ra  = ($urandom_range(0, 3) != 0);
            rka = int'($urandom_range(1, 1500));
            ru  = 1'($urandom_range(0, 1));
            rku = int'($urandom_range(rka + 2, 3990));
            rb  = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) begin
                r1[i] = 11'($urandom_range(0, 2047));
                r2[i] = 11'($urandom_range(0, 2047));
            end
            run_frame(ra, rka, ru, rku, r1, rb, r2);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drain", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
